// File: rtl/obi_copy_initiator.sv
// OBI block-copy initiator: for each word, one read then one write, with a single transaction
// outstanding. Optional XOR checksum of all words read is enabled by OBI_COPY_CHECKSUM_EN.

package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_copy_initiator
  import obi_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [31:0]          checksum_o,
  output obi_req_t             obi_req_o,
  input  obi_resp_t            obi_resp_i
);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StWrWait,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [31:0]          data_q, data_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
`ifdef OBI_COPY_CHECKSUM_EN
  logic [31:0]          cks_q, cks_d;
`endif

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    data_d    = data_q;
    rem_d     = rem_q;
`ifdef OBI_COPY_CHECKSUM_EN
    cks_d     = cks_q;
`endif
    obi_req_o = '0;
    done_o    = 1'b0;
    busy_o    = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          src_d   = {src_addr_i[31:2], 2'b00};
          dst_d   = {dst_addr_i[31:2], 2'b00};
          rem_d   = len_i;
`ifdef OBI_COPY_CHECKSUM_EN
          cks_d   = '0;
`endif
          state_d = (len_i == '0) ? StDone : StRdReq;
        end
      end
      StRdReq: begin
        obi_req_o.req  = 1'b1;
        obi_req_o.be   = 4'hF;
        obi_req_o.addr = src_q;
        if (obi_resp_i.gnt) state_d = StRdWait;
      end
      StRdWait: begin
        if (obi_resp_i.rvalid) begin
          data_d  = obi_resp_i.rdata;
`ifdef OBI_COPY_CHECKSUM_EN
          cks_d   = cks_q ^ obi_resp_i.rdata;
`endif
          state_d = StWrReq;
        end
      end
      StWrReq: begin
        obi_req_o.req   = 1'b1;
        obi_req_o.we    = 1'b1;
        obi_req_o.be    = 4'hF;
        obi_req_o.addr  = dst_q;
        obi_req_o.wdata = data_q;
        if (obi_resp_i.gnt) state_d = StWrWait;
      end
      StWrWait: begin
        // The write response retires the word; addresses wrap modulo 2**32.
        if (obi_resp_i.rvalid) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          rem_d   = rem_q - LEN_WIDTH'(1);
          state_d = (rem_q == LEN_WIDTH'(1)) ? StDone : StRdReq;
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
    end
  end

`ifdef OBI_COPY_CHECKSUM_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cks_q <= '0;
    else         cks_q <= cks_d;
  end

  assign checksum_o = cks_q;
`else
  assign checksum_o = 32'h0;
`endif

endmodule

// File: tb/tb_obi_copy_initiator.sv
// Bench for obi_copy_initiator: RAM responder with programmable grant delay, a write
// scoreboard filled at stimulus time and drained against observed writes after each copy.

module tb_obi_copy_initiator;
  import obi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done;
  logic [31:0] checksum;
  obi_req_t    obi_req;
  obi_resp_t   obi_resp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  obi_copy_initiator #(.LEN_WIDTH(16)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .src_addr_i (src_addr),
    .dst_addr_i (dst_addr),
    .len_i      (len),
    .busy_o     (busy),
    .done_o     (done),
    .checksum_o (checksum),
    .obi_req_o  (obi_req),
    .obi_resp_i (obi_resp)
  );

  always #5 clk = ~clk;

  // Responder model
  logic [31:0] mem [logic [31:0]];
  int          gnt_delay = 0;
  int          gcnt = 0;
  logic        rv_q = 1'b0;
  logic [31:0] rd_q = '0;
  logic [63:0] exp_q [$];
  logic [63:0] obs_q [$];
  logic [31:0] rd_addr_q [$];
  logic [31:0] exp_cks;
  int          viol = 0;
  bit          stall_q = 1'b0;
  obi_req_t    stall_req;

  always_comb begin
    obi_resp.gnt    = obi_req.req && (gcnt >= gnt_delay);
    obi_resp.rvalid = rv_q;
    obi_resp.rdata  = rd_q;
  end

  always @(posedge clk) begin
    cyc++;
    rv_q <= 1'b0;
    if (obi_req.req && obi_resp.gnt) begin
      rv_q <= 1'b1;
      gcnt <= 0;
      if (obi_req.we) begin
        mem[obi_req.addr] = obi_req.wdata;
        obs_q.push_back({obi_req.addr, obi_req.wdata});
      end else begin
        rd_q <= mem.exists(obi_req.addr) ? mem[obi_req.addr] : (32'hDEAD0000 ^ obi_req.addr);
        rd_addr_q.push_back(obi_req.addr);
      end
    end else if (obi_req.req) begin
      gcnt <= gcnt + 1;
    end else begin
      gcnt <= 0;
    end
    // A stalled request must hold every field until granted.
    if (rst_n && stall_q && obi_req !== stall_req) viol++;
    stall_q   = rst_n && obi_req.req && !obi_resp.gnt;
    stall_req = obi_req;
  end

  // Preload source words and push the expected destination writes.
  task automatic prep(input logic [31:0] src, input logic [31:0] dst, input int n,
                      input logic [31:0] seed, input bit rnd);
    logic [31:0] a, d;
    exp_q.delete();
    obs_q.delete();
    rd_addr_q.delete();
    exp_cks = '0;
    for (int i = 0; i < n; i++) begin
      a = src + 32'(4 * i);
      d = rnd ? $urandom() : seed * 32'(i + 1);
      mem[a] = d;
      exp_q.push_back({dst + 32'(4 * i), d});
      exp_cks ^= d;
    end
`ifndef OBI_COPY_CHECKSUM_EN
    exp_cks = '0;
`endif
  endtask

  // Start a copy and watch it to done; optionally re-pulse start mid-copy with other inputs.
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int n,
                          input int inj_cyc, output int lat, output int busy_cnt,
                          output int req_cnt, output bit done_after, output bit busy_after);
    int t0;
    lat = -1; busy_cnt = 0; req_cnt = 0;
    @(negedge clk);
    src_addr = src; dst_addr = dst; len = 16'(n); start = 1'b1;
    t0 = cyc;
    for (int k = 1; k < 2000; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == inj_cyc) begin
        src_addr = 32'h0000_0400; dst_addr = 32'h0000_0500; len = 16'd2; start = 1'b1;
      end
      if (busy) busy_cnt++;
      if (obi_req.req) req_cnt++;
      if (done) begin
        lat = cyc - t0;
        break;
      end
    end
    @(negedge clk);
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    if (checksum !== 32'h0) begin
      errors++; $display("FAIL reset_checksum got %h want 0", checksum);
    end
    if (obi_req !== '0) begin errors++; $display("FAIL reset_req got %h want 0", obi_req); end
  endtask

  task automatic test_basic();
    int lat, bc, rc; bit da, ba; logic [63:0] e, o;
    prep(32'h0, 32'h8000, 4, 32'h11, 1'b0);
    run_copy(32'h0, 32'h8000, 4, -1, lat, bc, rc, da, ba);
    checks += 6;
    if (lat !== 17) begin errors++; $display("FAIL basic_latency got %0d want 17", lat); end
    if (checksum !== exp_cks) begin
      errors++; $display("FAIL basic_checksum got %h want %h", checksum, exp_cks);
    end
    if (bc !== 17) begin errors++; $display("FAIL basic_busy_cycles got %0d want 17", bc); end
    if (rc !== 8) begin errors++; $display("FAIL basic_req_cycles got %0d want 8", rc); end
    if (da !== 1'b0) begin errors++; $display("FAIL basic_done_width got %0b want 0", da); end
    if (ba !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %0b want 0", ba); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hX;
      checks++;
      if (o !== e) begin errors++; $display("FAIL basic_write got %h want %h", o, e); end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL basic_extra_writes got %0d want 0", obs_q.size());
    end
  endtask

  task automatic test_len_zero();
    int lat, bc, rc; bit da, ba;
    prep(32'h40, 32'h80, 0, 32'h0, 1'b0);
    run_copy(32'h40, 32'h80, 0, -1, lat, bc, rc, da, ba);
    checks += 4;
    if (lat !== 1) begin errors++; $display("FAIL len0_latency got %0d want 1", lat); end
    if (bc !== 1) begin errors++; $display("FAIL len0_busy_cycles got %0d want 1", bc); end
    if (rc !== 0) begin errors++; $display("FAIL len0_req_cycles got %0d want 0", rc); end
    if (ba !== 1'b0) begin errors++; $display("FAIL len0_busy_after got %0b want 0", ba); end
  endtask

  task automatic test_gnt_stall();
    int lat, bc, rc; bit da, ba; logic [63:0] e, o;
    gnt_delay = 3;
    viol = 0;
    prep(32'h1000, 32'h2000, 3, 32'h0, 1'b1);
    run_copy(32'h1003, 32'h2002, 3, -1, lat, bc, rc, da, ba);
    gnt_delay = 0;
    checks += 4;
    if (viol !== 0) begin errors++; $display("FAIL stall_stability got %0d want 0", viol); end
    if (lat !== 31) begin errors++; $display("FAIL stall_latency got %0d want 31", lat); end
    if (rc !== 24) begin errors++; $display("FAIL stall_req_cycles got %0d want 24", rc); end
    if (checksum !== exp_cks) begin
      errors++; $display("FAIL stall_checksum got %h want %h", checksum, exp_cks);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hX;
      checks++;
      if (o !== e) begin errors++; $display("FAIL stall_write got %h want %h", o, e); end
    end
  endtask

  task automatic test_wrap();
    int lat, bc, rc; bit da, ba; logic [63:0] e, o; logic [31:0] ra;
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
    prep(32'hFFFF_FFF8, 32'h100, 3, 32'h0, 1'b1);
    run_copy(32'hFFFF_FFF8, 32'h100, 3, -1, lat, bc, rc, da, ba);
    for (int i = 0; i < 3; i++) begin
      ra = (rd_addr_q.size() > 0) ? rd_addr_q.pop_front() : 32'hX;
      checks++;
      if (ra !== want[i]) begin
        errors++; $display("FAIL wrap_read_addr%0d got %h want %h", i, ra, want[i]);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hX;
      checks++;
      if (o !== e) begin errors++; $display("FAIL wrap_write got %h want %h", o, e); end
    end
  endtask

  task automatic test_restart_ignored();
    int lat, bc, rc; bit da, ba; logic [63:0] e, o;
    prep(32'h200, 32'h300, 5, 32'h0, 1'b1);
    run_copy(32'h200, 32'h300, 5, 6, lat, bc, rc, da, ba);
    checks += 3;
    if (lat !== 21) begin errors++; $display("FAIL restart_latency got %0d want 21", lat); end
    if (checksum !== exp_cks) begin
      errors++; $display("FAIL restart_checksum got %h want %h", checksum, exp_cks);
    end
    if (obs_q.size() != 5) begin
      errors++; $display("FAIL restart_write_count got %0d want 5", obs_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hX;
      checks++;
      if (o !== e) begin errors++; $display("FAIL restart_write got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, rc; bit da, ba, hit; logic [63:0] e, o;
    hit = 1'b0;
    prep(32'h600, 32'h700, 3, 32'h0, 1'b1);
    @(negedge clk);
    src_addr = 32'h600; dst_addr = 32'h700; len = 16'd3; start = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (obi_req.req && obi_req.we && obi_req.addr == 32'h704) begin
        hit = 1'b1;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (obi_req.req !== 1'b0) begin
          errors++; $display("FAIL rstmid_req got %0b want 0", obi_req.req);
        end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", busy); end
        break;
      end
    end
    checks += 2;
    if (!hit) begin errors++; $display("FAIL rstmid_reach_wr2 got 0 want 1"); end
    @(negedge clk);
    rst_n = 1'b1;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL rstmid_partial_writes got %0d want 1", obs_q.size());
    end
    prep(32'h800, 32'h900, 2, 32'h0, 1'b1);
    run_copy(32'h800, 32'h900, 2, -1, lat, bc, rc, da, ba);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL rstmid_recopy_latency got %0d want 9", lat); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hX;
      checks++;
      if (o !== e) begin errors++; $display("FAIL rstmid_write got %h want %h", o, e); end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_len_zero();
    test_gnt_stall();
    test_wrap();
    test_restart_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
